uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
// - Read-side consumer of a circular fifo: pops bytes from the front of a fifo and serialises them as
//   asynchronous UART frames (start, data LSB-first, optional parity, stop) on a single tx line.
// - Sits between the host-bound transmit fifo and the FPGA tx pin.
// - Owns baud timing and the frame state machine.
// - The fifo's rd_data is the combinational front of the queue; rd_en pops it at the next clk edge.
//
// PARAMETERS
// - SYS_CLK_FREQ  50_000_000  system clock frequency in Hz
// - BAUD_RATE     38400       line rate in bits/s
// - DATA_BITS     8           data bits per frame; must match the fifo DATA_BITS
// - PARITY        0           0 = none, 1 = odd, 2 = even
// - STOP_BITS     1           stop bits per frame, 1 or 2
//
// PORTS
// - clk           in   1          system clock
// - reset         in   1          synchronous, active-high reset
// - fifo_empty    in   1          fifo empty flag; no pop is attempted while high
// - fifo_rd_data  in   DATA_BITS  current front of fifo
// - fifo_rd_en    out  1          single-cycle pop strobe to fifo
// - tx            out  1          serial output, idle high
// - busy          out  1          high from pop cycle through the last stop-bit cycle
//
// BEHAVIOUR
// - CLKS_PER_BIT = (SYS_CLK_FREQ + BAUD_RATE/2) / BAUD_RATE.
//   Elaboration error if CLKS_PER_BIT < 2, PARITY > 2, or STOP_BITS is not 1 or 2.
// - Baud counter width is $clog2(CLKS_PER_BIT).
//   It counts 0..CLKS_PER_BIT-1, restarts at every state entry, and never wraps mid-bit.
// - Reset (clk edge with reset=1):
//   - state=IDLE, tx=1, fifo_rd_en=0, busy=0.
//   - Shift register, bit index and counter are cleared.
// - Registered outputs: tx and busy are flops; fifo_rd_en is decoded from (state==IDLE && !fifo_empty).
// - IDLE:
//   - tx=1, busy=0.
//   - If !fifo_empty in cycle N: fifo_rd_en=1 in cycle N and fifo_rd_data is latched into the shift
//     register at the edge ending N. Parity is computed from the latched byte, and the next state is START.
//   - busy is driven high combinationally in cycle N, then held by its flop.
// - START: tx=0 for CLKS_PER_BIT cycles, beginning in cycle N+1. Then DATA with bit index 0.
// - DATA:
//   - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
//   - After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
// - PARITY: tx = odd ? ~^byte : ^byte, for CLKS_PER_BIT cycles. Then STOP.
// - STOP:
//   - tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//   - Exactly one IDLE cycle (tx=1) separates back-to-back frames.
// - fifo_rd_en:
//   - Asserted only in IDLE.
//   - Never asserted while fifo_empty=1.
//   - Never asserted for more than one consecutive cycle.
//   - fifo_empty/fifo_rd_data are ignored outside IDLE.
// - Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT + 1 clocks between successive pops.
// - Reset mid-frame:
//   - tx=1 and state=IDLE on the next cycle.
//   - The popped byte is discarded and not re-read.
// - Reset asserted together with !fifo_empty: reset wins and fifo_rd_en=0 in that cycle.
//
// TESTING  (bench: SYS_CLK_FREQ=1000, BAUD_RATE=100 -> CLKS_PER_BIT=10)
// - Reset for 3 cycles with fifo_empty=1
//   -> tx=1, busy=0, fifo_rd_en=0 held for 200 cycles.
// - Push 8'hA5, PARITY=0
//   -> one-cycle fifo_rd_en.
//   -> tx: 10 clks low, then 1,0,1,0,0,1,0,1 at 10 clks each, then 10 clks high.
//   -> busy falls after 101 clks.
// - Push 8'h03,8'h80,8'hFF back-to-back
//   -> three pops spaced exactly 101 clks apart.
//   -> Decoded bytes match in order; exactly 1 idle-high clk between frames.
// - PARITY=2 byte 8'h07 -> parity bit 1. PARITY=1 same byte -> parity bit 0.
//   -> STOP_BITS=2 frame is 120 clks of line time.
// - Assert reset at clk 45 of frame 8'h55, with a second byte queued
//   -> tx=1 next cycle; the next frame starts with a fresh pop of the queued byte (0x55 lost).
// - fifo_empty toggled every cycle during a frame
//   -> no fifo_rd_en until IDLE; fifo_rd_en never coincides with fifo_empty=1.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter that drains a fifo: pops one byte per frame and sends
// start, LSB-first data, optional parity and stop bits on an idle-high line.
module uart_tx #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE    = 38400,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic [2:0]           dbg_state_o
);

  localparam int CLKS_PER_BIT = (SYS_CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 bit_done;
  logic                 par_d;

  // Pop strobe is combinational so the fifo front is consumed in the same cycle it is seen.
  assign fifo_rd_en  = (state_q == S_IDLE) && !fifo_empty && !reset;
  assign busy        = busy_q | fifo_rd_en;
  assign tx          = tx_q;
  assign dbg_state_o = state_q;

  assign bit_done = (cnt_q == CNT_LAST);
  assign shift_d  = shift_q >> 1;
  assign par_d    = (PARITY == 1) ? ~^fifo_rd_data : ^fifo_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (fifo_rd_en) begin
            shift_q <= fifo_rd_data;
            par_q   <= par_d;
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
              idx_q   <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          // idx_q counts stop bits so the baud counter never exceeds one bit time.
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == STOP_LAST) begin
              idx_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even/2 stop, odd/1 stop)
// fed by bench fifos, with a per-cycle line model and a decoded-byte scoreboard.
module tb_uart_tx;

  localparam int CPB = (1000 + 100 / 2) / 100;

  logic       clk;
  logic       reset;
  logic       fifo_empty [3];
  logic [7:0] rd_data    [3];
  logic       rd_en      [3];
  logic       tx         [3];
  logic       busy       [3];
  logic [2:0] dbg_state  [3];

  logic [7:0] mem [3][32];
  int         wr_ptr [3];
  int         rd_ptr [3];
  logic       mask   [3];

  logic       exp_bits [3][128];
  int         exp_len  [3];
  int         exp_pos  [3];
  int         n_pop    [3];
  int         pop_t    [3][32];
  int         busy_run [3];
  int         last_run [3];

  logic [7:0] exp_q[$];
  logic       dec_active;
  int         dec_t;
  logic [7:0] dec_byte;

  int cyc;
  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .SYS_CLK_FREQ(1000),
      .BAUD_RATE   (100),
      .DATA_BITS   (8),
      .PARITY      (g == 1 ? 2 : (g == 2 ? 1 : 0)),
      .STOP_BITS   (g == 1 ? 2 : 1)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .fifo_empty  (fifo_empty[g]),
      .fifo_rd_data(rd_data[g]),
      .fifo_rd_en  (rd_en[g]),
      .tx          (tx[g]),
      .busy        (busy[g]),
      .dbg_state_o (dbg_state[g])
    );
    assign fifo_empty[g] = (rd_ptr[g] == wr_ptr[g]) || mask[g];
    assign rd_data[g]    = mem[g][rd_ptr[g]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int par_of(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction

  function automatic int stop_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line after a pop: each frame bit held for CPB clocks.
  task automatic build_line(input int g, input logic [7:0] b);
    logic lb [16];
    int   nb;
    int   ones;
    nb   = 0;
    ones = 0;
    lb[nb] = 1'b0;
    nb = nb + 1;
    for (int i = 0; i < 8; i++) begin
      lb[nb] = b[i];
      nb = nb + 1;
      ones = ones + int'(b[i]);
    end
    if (par_of(g) == 2) begin
      lb[nb] = (ones % 2 == 1);
      nb = nb + 1;
    end else if (par_of(g) == 1) begin
      lb[nb] = (ones % 2 == 0);
      nb = nb + 1;
    end
    for (int s = 0; s < stop_of(g); s++) begin
      lb[nb] = 1'b1;
      nb = nb + 1;
    end
    exp_len[g] = nb * CPB;
    exp_pos[g] = 0;
    for (int k = 0; k < nb * CPB; k++) exp_bits[g][k] = lb[k / CPB];
  endtask

  task automatic monitor();
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        chk($sformatf("rd_en_in_reset[%0d]", g), rd_en[g], 0);
        exp_len[g]  = 0;
        exp_pos[g]  = 0;
        busy_run[g] = 0;
        if (g == 0) dec_active = 1'b0;
        if (rd_en[g] === 1'b1) begin
          pop_t[g][n_pop[g]] = cyc;
          n_pop[g]++;
        end
      end else begin
        logic pending;
        logic exp_pop;
        pending = (exp_pos[g] < exp_len[g]);
        exp_pop = !pending && !fifo_empty[g];
        chk($sformatf("rd_en[%0d] cyc %0d", g, cyc), rd_en[g], exp_pop);
        if (pending) begin
          chk($sformatf("tx_frame[%0d] cyc %0d", g, cyc), tx[g], exp_bits[g][exp_pos[g]]);
          chk($sformatf("busy_frame[%0d] cyc %0d", g, cyc), busy[g], 1);
          exp_pos[g]++;
        end else begin
          chk($sformatf("tx_idle[%0d] cyc %0d", g, cyc), tx[g], 1);
          chk($sformatf("busy_idle[%0d] cyc %0d", g, cyc), busy[g], exp_pop);
        end
        if (busy[g] === 1'b1) busy_run[g]++;
        else if (busy_run[g] > 0) begin
          last_run[g] = busy_run[g];
          busy_run[g] = 0;
        end
        if (g == 0 && dec_active) begin
          int off;
          off = cyc - dec_t;
          if (off >= 15 && off <= 85 && (off - 15) % CPB == 0)
            dec_byte[(off - 15) / CPB] = tx[0];
          if (off == 85) begin
            dec_active = 1'b0;
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("decoded_byte", dec_byte, exp_q.pop_front());
          end
        end
        if (exp_pop) begin
          build_line(g, rd_data[g]);
          if (g == 0) begin
            dec_active = 1'b1;
            dec_t      = cyc;
          end
        end
        if (rd_en[g] === 1'b1) begin
          pop_t[g][n_pop[g]] = cyc;
          n_pop[g]++;
        end
      end
    end
  endtask

  task automatic tick();
    logic popped [3];
    @(negedge clk);
    monitor();
    for (int g = 0; g < 3; g++) popped[g] = rd_en[g];
    @(posedge clk);
    #1;
    cyc++;
    for (int g = 0; g < 3; g++) if (popped[g] === 1'b1) rd_ptr[g]++;
  endtask

  task automatic push(input int g, input logic [7:0] b);
    mem[g][wr_ptr[g]] = b;
    wr_ptr[g]++;
    if (g == 0) exp_q.push_back(b);
  endtask

  task automatic wait_pops(input int g, input int target, input int budget);
    int k;
    k = 0;
    while (n_pop[g] < target && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("pop_wait[%0d]", g), n_pop[g] >= target, 1);
  endtask

  initial begin
    int n0;
    int t0;
    int gap;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    dec_active = 1'b0;
    dec_t      = 0;
    dec_byte   = '0;
    for (int g = 0; g < 3; g++) begin
      wr_ptr[g]   = 0;
      rd_ptr[g]   = 0;
      mask[g]     = 1'b0;
      exp_len[g]  = 0;
      exp_pos[g]  = 0;
      n_pop[g]    = 0;
      busy_run[g] = 0;
      last_run[g] = 0;
      for (int i = 0; i < 32; i++) mem[g][i] = '0;
    end

    // Reset, then a long empty idle stretch.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (200) tick();
    for (int g = 0; g < 3; g++) chk($sformatf("idle_no_pop[%0d]", g), n_pop[g], 0);

    // Single byte, no parity.
    push(0, 8'hA5);
    wait_pops(0, 1, 5);
    repeat (105) tick();
    chk("busy_len_a5", last_run[0], 101);
    chk("sb_empty_a5", exp_q.size(), 0);

    // Back-to-back frames.
    push(0, 8'h03);
    push(0, 8'h80);
    push(0, 8'hFF);
    wait_pops(0, 4, 400);
    repeat (110) tick();
    chk("b2b_gap1", pop_t[0][2] - pop_t[0][1], 101);
    chk("b2b_gap2", pop_t[0][3] - pop_t[0][2], 101);
    chk("sb_empty_b2b", exp_q.size(), 0);

    // Parity: even/2-stop and odd/1-stop on the same byte.
    push(1, 8'h07);
    push(2, 8'h07);
    wait_pops(1, 1, 5);
    t0 = pop_t[1][0];
    chk("par_same_pop", pop_t[2][0], t0);
    while (cyc < t0 + 95) tick();
    chk("even_parity_bit", tx[1], 1);
    chk("odd_parity_bit", tx[2], 0);
    repeat (40) tick();
    chk("busy_len_even_2stop", last_run[1], 121);
    chk("busy_len_odd_1stop", last_run[2], 111);

    // Reset in the middle of a frame with a second byte queued.
    push(0, 8'h55);
    push(0, 8'h66);
    n0 = n_pop[0];
    wait_pops(0, n0 + 1, 5);
    t0 = pop_t[0][n0];
    while (cyc < t0 + 45) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_front());
    chk("tx_after_reset", tx[0], 1);
    chk("busy_after_reset_state", cyc, t0 + 46);
    wait_pops(0, n0 + 2, 5);
    chk("repop_time", pop_t[0][n0 + 1], t0 + 46);
    repeat (105) tick();
    chk("sb_empty_reset", exp_q.size(), 0);

    // Reset held while the fifo is non-empty.
    push(0, 8'h3C);
    reset = 1'b1;
    n0 = n_pop[0];
    repeat (2) tick();
    chk("no_pop_in_reset", n_pop[0], n0);
    reset = 1'b0;
    t0 = cyc;
    wait_pops(0, n0 + 1, 5);
    chk("pop_after_reset", pop_t[0][n0], t0);
    repeat (105) tick();

    // fifo_empty toggling every cycle across a frame.
    mask[0] = 1'b1;
    push(0, 8'($urandom_range(0, 255)));
    push(0, 8'($urandom_range(0, 255)));
    n0 = n_pop[0];
    for (int i = 0; i < 260; i++) begin
      tick();
      mask[0] = ~mask[0];
    end
    mask[0] = 1'b0;
    chk("toggle_pops", n_pop[0] - n0, 2);
    gap = pop_t[0][n0 + 1] - pop_t[0][n0];
    chk("toggle_gap", (gap == 101) || (gap == 102), 1);
    chk("sb_empty_toggle", exp_q.size(), 0);

    // Random bytes with random spacing on all instances.
    for (int j = 0; j < 3; j++) begin
      for (int g = 0; g < 3; g++) push(g, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 40)) tick();
    end
    repeat (500) tick();
    for (int g = 0; g < 3; g++) chk($sformatf("rand_pops[%0d]", g), n_pop[g], wr_ptr[g]);
    chk("sb_empty_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
